// File: rtl/counter_timer_ctrl.sv
// Timer control stage for the up/down counter: programs Load/direction/data,
// watches the counter's registered ripple-carry and raises done/irq/tally.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, stop       begin run (IDLE only) / abort run (any state)
//   mode_up           1=count up, 0=count down (latched at start)
//   auto_reload       1=reload on terminal, 0=one-shot (latched at start)
//   period            cycles per run (latched at start)
//   irq_clr           clears irq and err
//   rc_i              ripple-carry from counter
//   load_o, s_o       counter Load strobe and direction
//   pdata_o           counter parallel load value
//   busy              high in LOAD/ARM/RUN
//   done              one-cycle pulse per terminal event
//   irq, err          sticky event / zero-period error flags
//   tick_count        saturating terminal tally since last accepted start
module counter_timer_ctrl #(
    parameter int WIDTH = 32,
    parameter int TW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_up,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] period,
    input  logic             irq_clr,
    input  logic             rc_i,
    output logic             load_o,
    output logic             s_o,
    output logic [WIDTH-1:0] pdata_o,
    output logic             busy,
    output logic             done,
    output logic             irq,
    output logic             err,
    output logic [TW-1:0]    tick_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARM,
        RUN
    } state_t;

    state_t state, nxt;

    logic             mode_q;
    logic             ar_q;
    logic [WIDTH-1:0] per_q;

    logic             accept;
    logic             zero_err;
    logic             term;
    logic             mode_sel;
    logic [WIDTH-1:0] per_sel;
    logic [WIDTH-1:0] ld_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt      = state;
        accept   = 1'b0;
        zero_err = 1'b0;
        term     = 1'b0;
        if (stop) begin
            nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (period != '0) begin
                            accept = 1'b1;
                            nxt    = LOAD;
                        end else begin
                            zero_err = 1'b1;
                        end
                    end
                end
                LOAD: nxt = ARM;
                // rc_i here still reflects the count before the load
                ARM:  nxt = RUN;
                RUN: begin
                    if (rc_i) begin
                        term = 1'b1;
                        nxt  = ar_q ? LOAD : IDLE;
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    // On the accepting edge the latches are not yet loaded, so use inputs
    assign mode_sel = accept ? mode_up : mode_q;
    assign per_sel  = accept ? period  : per_q;
    assign ld_val   = mode_sel ? ({WIDTH{1'b1}} - per_sel) : per_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 1'b0;
            ar_q       <= 1'b0;
            per_q      <= '0;
            load_o     <= 1'b0;
            s_o        <= 1'b0;
            pdata_o    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            irq        <= 1'b0;
            err        <= 1'b0;
            tick_count <= '0;
        end else begin
            if (accept) begin
                mode_q <= mode_up;
                ar_q   <= auto_reload;
                per_q  <= period;
            end
            load_o <= (nxt == LOAD);
            if (nxt == LOAD) begin
                s_o     <= mode_sel;
                pdata_o <= ld_val;
            end
            busy <= (nxt != IDLE);
            done <= term;
            // a new event beats a same-cycle clear
            if (term)         irq <= 1'b1;
            else if (irq_clr) irq <= 1'b0;
            if (zero_err)     err <= 1'b1;
            else if (irq_clr) err <= 1'b0;
            if (accept)
                tick_count <= '0;
            else if (term && tick_count != {TW{1'b1}})
                tick_count <= tick_count + {{(TW-1){1'b0}}, 1'b1};
        end
    end

endmodule
